// File: rtl/slv_guard_rst_ctrl.sv
// Subordinate reset sequencer for a bus guard: asserts the subordinate reset,
// lets it settle, waits for ready with bounded retries, and latches a fault otherwise.
module slv_guard_rst_ctrl #(
  parameter int CntWidth   = 16,
  parameter int MaxRetries = 3,
  localparam int RetryWidth = $clog2(MaxRetries + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  rst_req_i,
  input  logic [CntWidth-1:0]   assert_cycles_i,
  input  logic [CntWidth-1:0]   settle_cycles_i,
  input  logic [CntWidth-1:0]   ready_timeout_i,
  input  logic                  sub_ready_i,
  input  logic                  clear_fault_i,
  output logic                  sub_rst_no,
  output logic                  isolate_o,
  output logic                  rst_stat_o,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic                  irq_o,
  output logic [RetryWidth-1:0] retry_cnt_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSERT   = 3'd1,
    SETTLE   = 3'd2,
    WAIT_RDY = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [RetryWidth-1:0] retry_q, retry_d;
  logic                  wait_forever_q, wait_forever_d;
  logic                  req_q;
  logic                  req_rise;

  assign req_rise = rst_req_i & ~req_q;

  // Phase counters hold "cycles remaining minus one", so a zero request still lasts one cycle.
  function automatic logic [CntWidth-1:0] phase_load(input logic [CntWidth-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    retry_d        = retry_q;
    wait_forever_d = wait_forever_q;
    unique case (state_q)
      IDLE: begin
        if (req_rise && en_i) begin
          state_d = ASSERT;
          cnt_d   = phase_load(assert_cycles_i);
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = phase_load(settle_cycles_i);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d        = WAIT_RDY;
          cnt_d          = ready_timeout_i;
          wait_forever_d = (ready_timeout_i == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_RDY: begin
        // Ready wins over a timeout landing in the same cycle.
        if (sub_ready_i) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (!wait_forever_q && cnt_q <= CntWidth'(1)) begin
          if (retry_q < RetryWidth'(MaxRetries)) begin
            retry_d = retry_q + 1'b1;
            state_d = ASSERT;
            cnt_d   = phase_load(assert_cycles_i);
          end else begin
            state_d = FAULT;
            cnt_d   = '0;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        retry_d = '0;
      end
      FAULT: begin
        if (clear_fault_i) begin
          state_d = IDLE;
          retry_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        retry_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      retry_q        <= '0;
      wait_forever_q <= 1'b0;
      req_q          <= 1'b0;
      sub_rst_no     <= 1'b1;
      isolate_o      <= 1'b0;
      busy_o         <= 1'b0;
      fault_o        <= 1'b0;
      rst_stat_o     <= 1'b0;
      irq_o          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      wait_forever_q <= wait_forever_d;
      req_q          <= rst_req_i;
      sub_rst_no     <= !(state_d == ASSERT || state_d == FAULT);
      isolate_o      <= (state_d != IDLE);
      busy_o         <= (state_d != IDLE);
      fault_o        <= (state_d == FAULT);
      rst_stat_o     <= (state_d == DONE);
      irq_o          <= (state_d == FAULT) && (state_q != FAULT);
    end
  end

  assign state_o     = state_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Randomized scoreboard bench for slv_guard_rst_ctrl with a reactive subordinate model
// and an outcome-level reference model of each reset sequence.
module tb_slv_guard_rst_ctrl;

  localparam int CntWidth   = 16;
  localparam int MaxRetries = 3;
  localparam int RetryWidth = $clog2(MaxRetries + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  en = 1'b0;
  logic                  rst_req = 1'b0;
  logic [CntWidth-1:0]   assert_cycles = '0;
  logic [CntWidth-1:0]   settle_cycles = '0;
  logic [CntWidth-1:0]   ready_timeout = '0;
  logic                  sub_ready = 1'b0;
  logic                  clear_fault = 1'b0;
  logic                  sub_rst_n;
  logic                  isolate;
  logic                  rst_stat;
  logic                  busy;
  logic                  fault;
  logic                  irq;
  logic [RetryWidth-1:0] retry_cnt;
  logic [2:0]            state;

  always #5 clk = ~clk;

  slv_guard_rst_ctrl #(.CntWidth(CntWidth), .MaxRetries(MaxRetries)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .rst_req_i(rst_req),
    .assert_cycles_i(assert_cycles), .settle_cycles_i(settle_cycles),
    .ready_timeout_i(ready_timeout), .sub_ready_i(sub_ready),
    .clear_fault_i(clear_fault), .sub_rst_no(sub_rst_n), .isolate_o(isolate),
    .rst_stat_o(rst_stat), .busy_o(busy), .fault_o(fault), .irq_o(irq),
    .retry_cnt_o(retry_cnt), .state_o(state)
  );

  typedef struct packed {
    int assert_len;
    int settle_len;
    int timeout;
    int wait_len;
    int attempts;
    bit is_fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Subordinate behaviour: ignores the first sub_fail resets of a sequence,
  // otherwise reports ready sub_delay cycles after its reset is released.
  int sub_delay = 1;
  int sub_fail  = 0;
  int seq_id    = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Outcome of one request: wait window opens after the settle phase, and the
  // subordinate is either ready inside it or every attempt times out.
  function automatic exp_t predict(input int a, input int s, input int t, input int d, input int k);
    exp_t e;
    bit   in_window;
    e.assert_len = (a == 0) ? 1 : a;
    e.settle_len = (s == 0) ? 1 : s;
    e.timeout    = t;
    e.wait_len   = (d > e.settle_len) ? d - e.settle_len : 1;
    in_window    = (t == 0) || (e.wait_len <= t);
    if (in_window && k <= MaxRetries) begin
      e.is_fault = 1'b0;
      e.attempts = k + 1;
    end else begin
      e.is_fault = 1'b1;
      e.attempts = MaxRetries + 1;
    end
    return e;
  endfunction

  task automatic waitState(input int lo, input int hi, input int budget, input string name);
    int n = 0;
    while (!(int'(state) >= lo && int'(state) <= hi) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(int'(state) >= lo && int'(state) <= hi)) checkOutput(name, int'(state), lo);
  endtask

  task automatic applyStimulus(input int a, input int s, input int t, input int d, input int k,
                               input bit en_drop);
    exp_t e;
    bit   single;
    e = predict(a, s, t, d, k);
    single = !e.is_fault && (e.attempts == 1);
    @(negedge clk);
    assert_cycles = CntWidth'(a);
    settle_cycles = CntWidth'(s);
    ready_timeout = CntWidth'(t);
    sub_delay = d;
    sub_fail  = k;
    seq_id++;
    exp_q.push_back(e);
    en = 1'b1;
    rst_req = 1'b1;
    waitState(1, 1, 20, "seq_start");
    if (en_drop) en = 1'b0;
    if (single) assert_cycles = CntWidth'($urandom_range(0, 15));
    rst_req = 1'b0;
    clear_fault = 1'b1;
    @(negedge clk);
    rst_req = 1'b1;
    clear_fault = 1'b0;
    waitState(3, 5, 200, "reach_wait");
    if (single && state == 3'd3) begin
      settle_cycles = CntWidth'($urandom_range(0, 15));
      ready_timeout = CntWidth'($urandom_range(1, 3));
    end
    waitState(4, 5, 1000, "seq_complete");
    if (state == 3'd5) begin
      repeat (3) @(negedge clk);
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
    end
    repeat (4) @(negedge clk);
    rst_req = 1'b0;
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin : subordinate
    int seen_seq = -1;
    int attempt_no = 0;
    int rel_cnt = 0;
    logic sub_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rel_cnt = 0;
        sub_prev = 1'b1;
        sub_ready = 1'b0;
      end else begin
        if (seen_seq != seq_id) begin
          seen_seq = seq_id;
          attempt_no = 0;
        end
        if (!sub_rst_n) begin
          if (sub_prev) attempt_no++;
          rel_cnt = 0;
        end else begin
          rel_cnt++;
        end
        sub_prev = sub_rst_n;
        sub_ready = (attempt_no > sub_fail) && (rel_cnt >= sub_delay);
      end
    end
  end

  initial begin : monitor
    int   s;
    int   prev_s = 0;
    int   run_len = 0;
    int   attempt = 0;
    bit   have_cur = 1'b0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_s = 0;
        run_len = 0;
        attempt = 0;
        have_cur = 1'b0;
      end else begin
        s = int'(state);
        checkOutput("legal_state", int'(s > 5), 0);
        checkOutput("sub_rst_n", int'(sub_rst_n), (s == 1 || s == 5) ? 0 : 1);
        checkOutput("isolate", int'(isolate), int'(s != 0));
        checkOutput("busy", int'(busy), int'(s != 0));
        checkOutput("fault", int'(fault), int'(s == 5));
        checkOutput("rst_stat", int'(rst_stat), int'(s == 4));
        checkOutput("irq", int'(irq), int'(s == 5 && prev_s != 5));
        if (s != prev_s) begin
          if (have_cur && prev_s == 1) checkOutput("assert_len", run_len, cur.assert_len);
          if (have_cur && prev_s == 2) checkOutput("settle_len", run_len, cur.settle_len);
          if (have_cur && prev_s == 3)
            checkOutput("wait_len", run_len, (s == 4) ? cur.wait_len : cur.timeout);
          if (prev_s == 4) begin
            checkOutput("done_len", run_len, 1);
            checkOutput("after_done", s, 0);
          end
          if (prev_s == 5) checkOutput("fault_exit", s, 0);
          if (s == 1) begin
            if (prev_s == 0) begin
              attempt = 1;
              if (exp_q.size() == 0) begin
                checkOutput("unexpected_start", 1, 0);
                have_cur = 1'b0;
              end else begin
                cur = exp_q[0];
                have_cur = 1'b1;
              end
            end else begin
              attempt++;
            end
            checkOutput("retry_cnt", int'(retry_cnt), attempt - 1);
          end
          if (s == 4 || s == 5) begin
            if (exp_q.size() == 0) begin
              checkOutput("unexpected_end", 1, 0);
            end else begin
              cur = exp_q.pop_front();
              checkOutput("outcome_fault", int'(s == 5), int'(cur.is_fault));
              checkOutput("attempts", attempt, cur.attempts);
            end
            have_cur = 1'b0;
          end
          run_len = 1;
        end else begin
          run_len++;
        end
        if (s == 0) checkOutput("idle_retry", int'(retry_cnt), 0);
        prev_s = s;
      end
    end
  end

  initial begin : driver
    int a, s, t, d, k, sl;
    exp_t e;
    #3 rst_n = 1'b0;
    #20;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_sub_rst_n", int'(sub_rst_n), 1);
    checkOutput("reset_isolate", int'(isolate), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_fault", int'(fault), 0);
    checkOutput("reset_irq", int'(irq), 0);
    checkOutput("reset_rst_stat", int'(rst_stat), 0);
    checkOutput("reset_retry", int'(retry_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(4, 2, 10, 3, 0, 1'b0);
    applyStimulus(0, 0, 5, 2, 0, 1'b0);
    applyStimulus(2, 1, 3, 1, 4, 1'b0);
    applyStimulus(3, 2, 4, 6, 0, 1'b1);
    applyStimulus(3, 2, 4, 7, 0, 1'b0);
    applyStimulus(1, 1, 2, 1, 2, 1'b1);
    applyStimulus(2, 3, 0, 20, 0, 1'b0);

    @(negedge clk);
    en = 1'b0;
    rst_req = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("en_off_idle", int'(state), 0);
    rst_req = 1'b0;
    en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 6);
      s = $urandom_range(0, 6);
      t = $urandom_range(0, 8);
      k = (t == 0) ? 0 : $urandom_range(0, 4);
      sl = (s == 0) ? 1 : s;
      d = (t == 0) ? $urandom_range(1, 12) : $urandom_range(1, sl + t + 2);
      applyStimulus(a, s, t, d, k, 1'(($urandom & 1)));
    end

    // Async reset in the middle of SETTLE, with the request still held high.
    @(negedge clk);
    assert_cycles = 16'd5;
    settle_cycles = 16'd6;
    ready_timeout = 16'd10;
    sub_delay = 2;
    sub_fail = 0;
    seq_id++;
    exp_q.push_back(predict(5, 6, 10, 2, 0));
    en = 1'b1;
    rst_req = 1'b1;
    waitState(2, 2, 50, "reach_settle");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_state", int'(state), 0);
    checkOutput("abort_sub_rst_n", int'(sub_rst_n), 1);
    checkOutput("abort_isolate", int'(isolate), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_fault", int'(fault), 0);
    checkOutput("abort_irq", int'(irq), 0);
    checkOutput("abort_rst_stat", int'(rst_stat), 0);
    checkOutput("abort_retry", int'(retry_cnt), 0);
    exp_q.delete();
    @(negedge clk);
    e = predict(5, 6, 10, 2, 0);
    seq_id++;
    exp_q.push_back(e);
    #1 rst_n = 1'b1;
    waitState(1, 1, 20, "restart_after_reset");
    waitState(4, 5, 1000, "restart_complete");
    repeat (3) @(negedge clk);
    rst_req = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slv_guard_rst_ctrl.md
SLV_GUARD_RST_CTRL -- requirements
Module: slv_guard_rst_ctrl

Interface
REQ-001 SHALL have parameter CntWidth, default 16, width of all cycle-count config inputs and internal counter.
REQ-002 SHALL have parameter MaxRetries, default 3, number of reset retries before fault; retry counter width $clog2(MaxRetries+1).
REQ-003 SHALL have port clk_i  input  1  clock; single clock domain.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en_i  input  1  controller enable; sampled only in IDLE.
REQ-006 SHALL have port rst_req_i  input  1  reset request from guard; level, acted on at rising edge.
REQ-007 SHALL have port assert_cycles_i  input  CntWidth  subordinate reset-low duration.
REQ-008 SHALL have port settle_cycles_i  input  CntWidth  post-release settle duration.
REQ-009 SHALL have port ready_timeout_i  input  CntWidth  ready wait limit; 0 = wait forever.
REQ-010 SHALL have port sub_ready_i  input  1  subordinate reports initialised.
REQ-011 SHALL have port clear_fault_i  input  1  software fault clear.
REQ-012 SHALL have port sub_rst_no  output  1  active-low reset to subordinate.
REQ-013 SHALL have port isolate_o  output  1  guard must block traffic to subordinate.
REQ-014 SHALL have port rst_stat_o  output  1  one-cycle recovery-complete pulse to guard reset_clear.
REQ-015 SHALL have ports busy_o (1), fault_o (1), irq_o (1), retry_cnt_o (retry width), state_o (3)  outputs  status.

Function
REQ-016 SHALL implement FSM IDLE=0, ASSERT=1, SETTLE=2, WAIT_RDY=3, DONE=4, FAULT=5, exposed on state_o.
REQ-017 SHALL detect rising edge of rst_req_i via registered previous value; edge in IDLE with en_i=1 -> ASSERT, counter loaded.
REQ-018 SHALL ignore rst_req_i edges in any state other than IDLE; no queueing.
REQ-019 ASSERT: sub_rst_no=0 for exactly max(assert_cycles_i,1) cycles, then SETTLE.
REQ-020 SETTLE: sub_rst_no=1 for exactly max(settle_cycles_i,1) cycles, then WAIT_RDY.
REQ-021 WAIT_RDY: sub_ready_i=1 -> DONE next cycle; takes priority over timeout in the same cycle.
REQ-022 WAIT_RDY timeout after ready_timeout_i cycles without ready: retry_cnt<MaxRetries -> retry_cnt+1, ASSERT; else FAULT.
REQ-023 DONE lasts one cycle: rst_stat_o=1, retry_cnt cleared, next state IDLE.
REQ-024 FAULT: sub_rst_no=0 held, fault_o=1; exit to IDLE only on clear_fault_i, clearing retry_cnt; clear_fault_i ignored elsewhere.
REQ-025 irq_o SHALL pulse one cycle on the transition into FAULT only.
REQ-026 isolate_o=1 and busy_o=1 in every state except IDLE.
REQ-027 Config inputs SHALL be sampled at counter load; changes mid-phase SHALL not affect the running phase.
REQ-028 en_i deasserted outside IDLE SHALL not abort a running sequence.
REQ-029 Counter SHALL saturate/stop at terminal value; no wrap-around.

Reset
REQ-030 On rst_ni=0: state IDLE, counter 0, retry_cnt 0, edge register 0; sub_rst_no=1, isolate_o=0, rst_stat_o=0, busy_o=0, fault_o=0, irq_o=0.
REQ-031 rst_req_i already high at reset release SHALL count as a rising edge.
REQ-032 Reset asserted mid-sequence SHALL abort immediately to the REQ-030 values.

Verification
REQ-033 Nominal: assert=4, settle=2, timeout=10, ready 1 cycle into WAIT_RDY -> sub_rst_no low 4 cycles, rst_stat_o pulse 1 cycle, back to IDLE, retry_cnt=0.
REQ-034 Zero config: assert=0, settle=0 -> sub_rst_no low exactly 1 cycle, SETTLE 1 cycle.
REQ-035 Retry/fault: timeout=3, ready never -> 3 retries (retry_cnt 1..3), then FAULT, irq_o one pulse, sub_rst_no held 0; clear_fault_i -> IDLE, retry_cnt=0.
REQ-036 Level hold: rst_req_i held high through DONE -> no second sequence until rst_req_i drops and rises again.
REQ-037 Race: sub_ready_i rises on the timeout cycle -> DONE, no retry; en_i=0 in ASSERT -> sequence completes.
REQ-038 Async reset in SETTLE -> outputs at REQ-030 values same cycle; rst_req_i high at release -> new sequence starts.
